// File: rtl/ip_to_mac_pkg.sv
// Shared types and widths for the IP->MAC lookup arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: address widths used on the requester and lookup-unit buses,
// and the arbiter FSM state encoding.
package ip_to_mac_pkg;

   localparam int IP_ADDR_W  = 32;
   localparam int MAC_ADDR_W = 48;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ip_to_mac_arb_rr_arbiter.sv
// Round-robin selector: first asserted request at or above the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   REQ_W    index that has highest priority this cycle
//   gnt     out  NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx out  REQ_W    binary index of the grant
//   gnt_any out  1        at least one request asserted
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int REQ_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [REQ_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [REQ_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   logic [REQ_W-1:0] w_cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = REQ_W'((int'(ptr) + k) % NUM_REQ);
         if (!gnt_any && req[w_cand]) begin
            gnt_any     = 1'b1;
            gnt[w_cand] = 1'b1;
            gnt_idx     = w_cand;
         end
      end
   end

endmodule

// File: rtl/ip_to_mac_arb.sv
// Round-robin sequencer sharing one IP->MAC lookup unit among NUM_REQ requesters.
// Latency: accept in cycle N, lookup in N+1, resp_val from N+2; accepts >= 3 cycles apart.
// Backpressure: one request in flight; no new grant until the winner takes its response.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_ip_val/addr/rdy        requester side (addr packed, requester i at [i*IP_ADDR_W +: IP_ADDR_W])
//   resp_val/mac_addr/hit/rdy  response back to the winner (mac/hit shared, qualified by resp_val)
//   lkup_*                     handshake to the single lookup unit
//   stat_hit_cnt/miss_cnt      only when IP_TO_MAC_ARB_STATS_EN is defined
module ip_to_mac_arb
   import ip_to_mac_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_ip_val,
   input  logic [NUM_REQ*IP_ADDR_W-1:0]   req_ip_addr,
   output logic [NUM_REQ-1:0]             req_ip_rdy,
   output logic [NUM_REQ-1:0]             resp_val,
   output logic [MAC_ADDR_W-1:0]          resp_mac_addr,
   output logic                           resp_hit,
   input  logic [NUM_REQ-1:0]             resp_rdy,
   output logic [IP_ADDR_W-1:0]           lkup_ip_addr,
   output logic                           lkup_ip_val,
   input  logic                           lkup_ip_rdy,
   input  logic [MAC_ADDR_W-1:0]          lkup_mac_addr,
   input  logic                           lkup_mac_val,
   input  logic                           lkup_mac_hit,
   output logic                           lkup_mac_rdy
`ifdef IP_TO_MAC_ARB_STATS_EN
   ,
   output logic [31:0]                    stat_hit_cnt,
   output logic [31:0]                    stat_miss_cnt
`endif
);

   localparam int REQ_W = $clog2(NUM_REQ);

   arb_state_e             r_state;
   arb_state_e             w_next_state;
   logic [REQ_W-1:0]       r_ptr;
   logic [REQ_W-1:0]       r_win;
   logic [IP_ADDR_W-1:0]   r_ip;
   logic [MAC_ADDR_W-1:0]  r_mac;
   logic                   r_hit;

   logic [NUM_REQ-1:0]     w_gnt;
   logic [REQ_W-1:0]       w_gnt_idx;
   logic                   w_gnt_any;
   logic [IP_ADDR_W-1:0]   w_sel_ip;
   logic                   w_accept;
   logic                   w_lkup_done;
   logic                   w_resp_done;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .REQ_W   (REQ_W)
   ) u_rr (
      .req     (req_ip_val),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .gnt_any (w_gnt_any)
   );

   assign w_sel_ip    = req_ip_addr[w_gnt_idx*IP_ADDR_W +: IP_ADDR_W];
   // The grant only ever covers asserted requests, so any grant in IDLE is an accept.
   assign w_accept    = (r_state == IDLE) && w_gnt_any;
   // Lookup completes only when both halves of the lookup handshake are present.
   assign w_lkup_done = (r_state == LOOKUP) && lkup_mac_val && lkup_ip_rdy;
   assign w_resp_done = (r_state == RESP) && resp_rdy[r_win];

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept)    w_next_state = LOOKUP;
         LOOKUP:  if (w_lkup_done) w_next_state = RESP;
         RESP:    if (w_resp_done) w_next_state = IDLE;
         default:                  w_next_state = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ip_rdy    = '0;
      resp_val      = '0;
      resp_mac_addr = '0;
      resp_hit      = 1'b0;
      lkup_ip_addr  = '0;
      lkup_ip_val   = 1'b0;
      lkup_mac_rdy  = 1'b0;
      case (r_state)
         IDLE: req_ip_rdy = w_gnt;
         LOOKUP: begin
            lkup_ip_val  = 1'b1;
            lkup_mac_rdy = 1'b1;
            lkup_ip_addr = r_ip;
         end
         RESP: begin
            resp_val      = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;
            resp_mac_addr = r_mac;
            resp_hit      = r_hit;
         end
         default: ;
      endcase
   end

   // Request/response latches and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_win <= '0;
         r_ip  <= '0;
         r_mac <= '0;
         r_hit <= 1'b0;
      end else begin
         if (w_accept) begin
            r_win <= w_gnt_idx;
            r_ip  <= w_sel_ip;
            r_ptr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
         end
         if (w_lkup_done) begin
            // A miss returns an all-zero MAC regardless of what the lookup bus carries.
            r_mac <= lkup_mac_hit ? lkup_mac_addr : '0;
            r_hit <= lkup_mac_hit;
         end
      end
   end

`ifdef IP_TO_MAC_ARB_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_lkup_done) begin
         if (lkup_mac_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
         else              r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign stat_hit_cnt  = r_hit_cnt;
   assign stat_miss_cnt = r_miss_cnt;
`endif

endmodule
